// File: rtl/fifo_sync_param_if.sv
// Handshake bundle for fifo_sync_param: the producer/consumer side is the master,
// the FIFO itself is the slave.
interface fifo_sync_param_if #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic                  push;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  pop;
    logic                  clr_err;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  rvalid;
    logic                  full;
    logic                  empty;
    logic                  almost_full;
    logic                  almost_empty;
    logic [CW-1:0]         count;
    logic                  overflow;
    logic                  underflow;

    modport master (
        output push, wdata, pop, clr_err,
        input  rdata, rvalid, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );

    modport slave (
        input  push, wdata, pop, clr_err,
        output rdata, rvalid, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );
endinterface

// File: rtl/fifo_sync_param.sv
// Single-clock circular-buffer FIFO with registered status flags, sticky error
// flags and a choice of registered or first-word-fall-through read port.
module fifo_sync_param #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int AF_LEVEL   = DEPTH - 2,
    parameter int AE_LEVEL   = 2,
    parameter int FWFT       = 0
) (
    input  logic               clk,
    input  logic               rst,
    fifo_sync_param_if.slave   bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    generate
        if (((DEPTH & (DEPTH - 1)) != 0) || (DEPTH < 4)) begin : g_bad_depth
            $error("fifo_sync_param: DEPTH must be a power of 2 and at least 4");
        end
        if (!((AE_LEVEL >= 1) && (AE_LEVEL < AF_LEVEL) && (AF_LEVEL <= DEPTH - 1))) begin : g_bad_levels
            $error("fifo_sync_param: need 1 <= AE_LEVEL < AF_LEVEL <= DEPTH-1");
        end
    endgenerate

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]         r_wptr;
    logic [PW-1:0]         r_rptr;
    logic [CW-1:0]         r_count;
    logic                  r_full;
    logic                  r_empty;
    logic                  r_almost_full;
    logic                  r_almost_empty;
    logic                  r_overflow;
    logic                  r_underflow;

    logic                  w_push_ok;
    logic                  w_pop_ok;
    logic [CW-1:0]         w_count_nxt;
    logic [DATA_WIDTH-1:0] w_rdata;
    logic                  w_rvalid;

    // A push during reset is dropped so it can never land in storage.
    assign w_push_ok = bus.push & ~r_full & ~rst;
    assign w_pop_ok  = bus.pop  & ~r_empty & ~rst;

    // NOTE: every variable driven here gets a default first, so no path leaves it
    // unassigned and no latch is inferred.
    always_comb begin
        w_count_nxt = r_count;
        unique case ({w_push_ok, w_pop_ok})
            2'b10:   w_count_nxt = r_count + CW'(1);
            2'b01:   w_count_nxt = r_count - CW'(1);
            default: w_count_nxt = r_count;
        endcase
    end

    // NOTE: the storage array has no reset; pointers guarantee a slot is written
    // before it is read, and leaving it unreset lets it map onto RAM.
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wptr] <= bus.wdata;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr         <= '0;
            r_rptr         <= '0;
            r_count        <= '0;
            r_full         <= 1'b0;
            r_empty        <= 1'b1;
            r_almost_full  <= 1'b0;
            r_almost_empty <= 1'b1;
        end else begin
            if (w_push_ok) begin
                r_wptr <= r_wptr + PW'(1);
            end
            if (w_pop_ok) begin
                r_rptr <= r_rptr + PW'(1);
            end
            r_count        <= w_count_nxt;
            r_full         <= (w_count_nxt == CW'(DEPTH));
            r_empty        <= (w_count_nxt == '0);
            r_almost_full  <= (w_count_nxt >= CW'(AF_LEVEL));
            r_almost_empty <= (w_count_nxt <= CW'(AE_LEVEL));
        end
    end

    // A fresh error in the same cycle as clr_err wins, so the flag stays set.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (bus.push && r_full) begin
                r_overflow <= 1'b1;
            end else if (bus.clr_err) begin
                r_overflow <= 1'b0;
            end
            if (bus.pop && r_empty) begin
                r_underflow <= 1'b1;
            end else if (bus.clr_err) begin
                r_underflow <= 1'b0;
            end
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            // Head word is shown directly; masked to zero while empty so the
            // output matches the reset value and never exposes stale storage.
            assign w_rdata  = r_empty ? '0 : r_mem[r_rptr];
            assign w_rvalid = ~r_empty;
        end else begin : g_std
            logic [DATA_WIDTH-1:0] r_rdata;
            logic                  r_rvalid;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_rdata  <= '0;
                    r_rvalid <= 1'b0;
                end else begin
                    r_rvalid <= w_pop_ok;
                    if (w_pop_ok) begin
                        r_rdata <= r_mem[r_rptr];
                    end
                end
            end

            assign w_rdata  = r_rdata;
            assign w_rvalid = r_rvalid;
        end
    endgenerate

    assign bus.rdata        = w_rdata;
    assign bus.rvalid       = w_rvalid;
    assign bus.full         = r_full;
    assign bus.empty        = r_empty;
    assign bus.almost_full  = r_almost_full;
    assign bus.almost_empty = r_almost_empty;
    assign bus.count        = r_count;
    assign bus.overflow     = r_overflow;
    assign bus.underflow    = r_underflow;
endmodule

// File: tb/tb_fifo_sync_param.sv
// Scoreboard bench for fifo_sync_param: a registered-read instance checked through
// an expected-read queue, plus a first-word-fall-through instance checked directly.
module tb_fifo_sync_param;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;

    typedef struct {
        logic [7:0] data;
        int         due;
    } exp_t;

    exp_t exp_q[$];

    fifo_sync_param_if #(.DATA_WIDTH(8), .DEPTH(16)) bus0 ();
    fifo_sync_param_if #(.DATA_WIDTH(8), .DEPTH(16)) bus1 ();

    fifo_sync_param #(.DATA_WIDTH(8), .DEPTH(16), .FWFT(0)) u_std (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    fifo_sync_param #(.DATA_WIDTH(8), .DEPTH(16), .FWFT(1)) u_fwft (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every rvalid pulse must match the oldest expected read, on time.
    always @(negedge clk) begin
        if (!rst && bus0.rvalid) begin
            exp_t e;
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL rd_unexpected: got rvalid rdata=%02h at cycle %0d, required no read", bus0.rdata, cyc);
            end else begin
                e = exp_q.pop_front();
                if (bus0.rdata !== e.data || cyc != e.due) begin
                    n_err++;
                    $display("FAIL rd_data: got %02h at cycle %0d, required %02h at cycle %0d", bus0.rdata, cyc, e.data, e.due);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One cycle on the registered-read instance; ev/ed queue an expected read.
    task automatic do_op(input bit p, input logic [7:0] d, input bit q, input bit c,
                         input bit ev, input logic [7:0] ed);
        bus0.push    = p;
        bus0.wdata   = d;
        bus0.pop     = q;
        bus0.clr_err = c;
        if (ev) exp_q.push_back('{data: ed, due: cyc + 1});
        step();
        bus0.push    = 1'b0;
        bus0.pop     = 1'b0;
        bus0.clr_err = 1'b0;
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_count"}, 32'(bus0.count), 0);
        check({tag, "_empty"}, 32'(bus0.empty), 1);
        check({tag, "_aempty"}, 32'(bus0.almost_empty), 1);
        check({tag, "_full"}, 32'(bus0.full), 0);
        check({tag, "_afull"}, 32'(bus0.almost_full), 0);
        check({tag, "_rvalid"}, 32'(bus0.rvalid), 0);
        check({tag, "_rdata"}, 32'(bus0.rdata), 0);
        check({tag, "_ovf"}, 32'(bus0.overflow), 0);
        check({tag, "_unf"}, 32'(bus0.underflow), 0);
    endtask

    initial begin
        int  nw, nr, occ, t;
        bit  p, q, up;

        bus0.push = 0; bus0.wdata = '0; bus0.pop = 0; bus0.clr_err = 0;
        bus1.push = 0; bus1.wdata = '0; bus1.pop = 0; bus1.clr_err = 0;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        check_reset("rst");

        // Fill to full, then an extra push together with clr_err: error wins.
        for (int k = 1; k <= 16; k++) begin
            do_op(1, 8'(k), 0, 0, 0, 0);
            check("fill_count", 32'(bus0.count), k);
            check("fill_afull", 32'(bus0.almost_full), (k >= 14) ? 1 : 0);
            check("fill_full", 32'(bus0.full), (k == 16) ? 1 : 0);
            check("fill_aempty", 32'(bus0.almost_empty), (k <= 2) ? 1 : 0);
        end
        do_op(1, 8'hAA, 0, 1, 0, 0);
        check("ovf_count", 32'(bus0.count), 16);
        check("ovf_flag", 32'(bus0.overflow), 1);
        check("ovf_full", 32'(bus0.full), 1);
        check("ovf_unf", 32'(bus0.underflow), 0);
        for (int k = 1; k <= 16; k++) begin
            do_op(0, 0, 1, 0, 1, 8'(k));
            check("drain_count", 32'(bus0.count), 16 - k);
        end
        step();
        check("drain_empty", 32'(bus0.empty), 1);
        check("hold_rvalid", 32'(bus0.rvalid), 0);
        check("hold_rdata", 32'(bus0.rdata), 32'h10);
        do_op(0, 0, 0, 1, 0, 0);
        check("clr_ovf", 32'(bus0.overflow), 0);

        // Wrap-around: 40 words, occupancy bounced between 1 and 10.
        nw = 0; nr = 0; occ = 0; t = 0; up = 1;
        while (nr < 40 && t < 400) begin
            if (up && occ >= 10) up = 0;
            if (!up && occ <= 1) up = 1;
            p = (nw < 40) && (up || (t % 3 == 0)) && (occ < 10);
            q = ((occ > 1) && (!up || (t % 4 == 0))) || ((nw == 40) && (occ > 0));
            do_op(p, 8'(nw), q, 0, q, 8'(nr));
            if (p) nw++;
            if (q) nr++;
            occ = occ + int'(p) - int'(q);
            t++;
        end
        step();
        check("wrap_reads", nr, 40);
        check("wrap_count", 32'(bus0.count), 0);
        check("wrap_ovf", 32'(bus0.overflow), 0);
        check("wrap_unf", 32'(bus0.underflow), 0);

        // Simultaneous push+pop at count 8, 0 and 16.
        for (int k = 0; k < 8; k++) do_op(1, 8'(8'h80 + k), 0, 0, 0, 0);
        do_op(1, 8'h88, 1, 0, 1, 8'h80);
        check("sim8_count", 32'(bus0.count), 8);
        for (int k = 1; k <= 8; k++) do_op(0, 0, 1, 0, 1, 8'(8'h80 + k));
        step();
        check("sim0_pre", 32'(bus0.count), 0);
        do_op(1, 8'h99, 1, 0, 0, 0);
        check("sim0_count", 32'(bus0.count), 1);
        check("sim0_unf", 32'(bus0.underflow), 1);
        do_op(0, 0, 0, 1, 0, 0);
        check("sim0_clr", 32'(bus0.underflow), 0);
        for (int k = 0; k < 15; k++) do_op(1, 8'(8'hA0 + k), 0, 0, 0, 0);
        check("sim16_full", 32'(bus0.full), 1);
        do_op(1, 8'hBB, 1, 0, 1, 8'h99);
        check("sim16_count", 32'(bus0.count), 15);
        check("sim16_ovf", 32'(bus0.overflow), 1);
        check("sim16_nfull", 32'(bus0.full), 0);
        for (int k = 0; k < 15; k++) do_op(0, 0, 1, 0, 1, 8'(8'hA0 + k));
        step();

        // Error clear race: clr_err together with a pop on empty.
        do_op(0, 0, 1, 1, 0, 0);
        check("race_ovf", 32'(bus0.overflow), 0);
        check("race_unf", 32'(bus0.underflow), 1);
        do_op(0, 0, 0, 1, 0, 0);

        // Reset mid-operation with a concurrent push of 0x33.
        for (int k = 0; k < 9; k++) do_op(1, 8'(8'h40 + k), 0, 0, 0, 0);
        check("mid_count", 32'(bus0.count), 9);
        rst = 1'b1;
        bus0.push = 1'b1;
        bus0.wdata = 8'h33;
        step();
        rst = 1'b0;
        bus0.push = 1'b0;
        check_reset("midrst");
        do_op(1, 8'h55, 0, 0, 0, 0);
        do_op(0, 0, 1, 0, 1, 8'h55);
        step();
        check("midrst_empty", 32'(bus0.empty), 1);

        // First-word-fall-through instance.
        check("fw_rst_rvalid", 32'(bus1.rvalid), 0);
        check("fw_rst_rdata", 32'(bus1.rdata), 0);
        bus1.push = 1; bus1.wdata = 8'h5A;
        step();
        bus1.push = 0;
        check("fw_n1_rdata", 32'(bus1.rdata), 32'h5A);
        check("fw_n1_rvalid", 32'(bus1.rvalid), 1);
        step();
        check("fw_hold_rdata", 32'(bus1.rdata), 32'h5A);
        bus1.pop = 1;
        step();
        bus1.pop = 0;
        check("fw_pop_rvalid", 32'(bus1.rvalid), 0);
        check("fw_pop_empty", 32'(bus1.empty), 1);
        bus1.push = 1; bus1.wdata = 8'h11;
        step();
        bus1.wdata = 8'h22;
        step();
        bus1.push = 0;
        check("fw_two_head", 32'(bus1.rdata), 32'h11);
        bus1.pop = 1;
        step();
        check("fw_next_rdata", 32'(bus1.rdata), 32'h22);
        check("fw_next_rvalid", 32'(bus1.rvalid), 1);
        step();
        bus1.pop = 0;
        check("fw_last_rvalid", 32'(bus1.rvalid), 0);
        check("fw_last_count", 32'(bus1.count), 0);

        step();
        check("scoreboard_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/fifo_sync_param.md
FIFO_SYNC_PARAM -- requirements
Module: fifo_sync_param

Interface
REQ-001 SHALL provide parameters (name, default, meaning), one per line:
- DATA_WIDTH, 8, word width in bits.
- DEPTH, 16, number of entries; power of 2, at least 4.
- AF_LEVEL, DEPTH-2, almost_full threshold.
- AE_LEVEL, 2, almost_empty threshold.
- FWFT, 0, read mode: 0 = standard registered read, 1 = first-word-fall-through.

REQ-002 SHALL provide ports (name, direction, width, meaning), one per line:
- clk, in, 1, single clock for all logic.
- rst, in, 1, synchronous, active-high reset.
- push, in, 1, write request.
- wdata, in, DATA_WIDTH, write data.
- pop, in, 1, read request (in FWFT mode, acknowledge of the head word).
- rdata, out, DATA_WIDTH, read data.
- rvalid, out, 1, rdata holds valid data.
- full, out, 1, count == DEPTH.
- empty, out, 1, count == 0.
- almost_full, out, 1, count >= AF_LEVEL.
- almost_empty, out, 1, count <= AE_LEVEL.
- count, out, $clog2(DEPTH)+1, current occupancy.
- overflow, out, 1, sticky: a push was attempted while full.
- underflow, out, 1, sticky: a pop was attempted while empty.
- clr_err, in, 1, clears overflow and underflow.

REQ-003 SHALL use only clk for all sequential logic; rst is synchronous and active-high.

Function
REQ-004 SHALL store up to DEPTH words in circular storage with $clog2(DEPTH)-bit read and write pointers that wrap modulo DEPTH.
REQ-005 SHALL accept a push only when full=0; an accepted push writes wdata at the write pointer and increments it.
REQ-006 SHALL accept a pop only when empty=0; an accepted pop advances the read pointer.
REQ-007 SHALL leave count unchanged on a simultaneous accepted push and pop; otherwise +1 per accepted push and -1 per accepted pop.
REQ-008 SHALL drop a push attempted while full: storage, pointers and count unchanged; overflow=1 from the next cycle.
REQ-009 SHALL ignore a pop attempted while empty: pointers, count and rdata unchanged; underflow=1 from the next cycle.
REQ-010 SHALL, at count=0 with push and pop both asserted, accept the push, reject the pop (underflow set), and give count=1 on the next cycle.
REQ-011 SHALL, at count=DEPTH with push and pop both asserted, accept the pop, reject the push (overflow set), and give count=DEPTH-1 on the next cycle.
REQ-012 SHALL drive full, empty, almost_full, almost_empty and count from registered state, updating on the cycle after the causing event.
REQ-013 SHALL, with FWFT=0, present the popped word on rdata with rvalid=1 exactly one cycle after the accepted pop; rvalid is a one-cycle pulse and rdata holds its value between pops.
REQ-014 SHALL, with FWFT=1, drive rdata with the head word and rvalid = !empty continuously; a word pushed into an empty FIFO at cycle N appears on rdata with rvalid=1 at cycle N+1.
REQ-015 SHALL, with FWFT=1, treat pop as consuming the current head; the next word, or rvalid=0 if the FIFO empties, appears at the next cycle.
REQ-016 SHALL clear overflow and underflow on clr_err; a new error event in the same cycle takes priority and the flag stays 1.
REQ-017 SHALL fail elaboration if DEPTH is not a power of 2, if DEPTH < 4, or if 1 <= AE_LEVEL < AF_LEVEL <= DEPTH-1 does not hold.

Reset
REQ-018 SHALL, on rst=1 at a clk edge, set pointers=0, count=0, empty=1, almost_empty=1, full=0, almost_full=0, rvalid=0, rdata=0, overflow=0, underflow=0.
REQ-019 SHALL give rst priority over push, pop and clr_err in the same cycle; storage contents are not reset and are never read before being rewritten.

Verification (DATA_WIDTH=8, DEPTH=16, FWFT=0 unless stated)
REQ-020 Fill and overflow: push 0x01..0x10, then push 0xAA -> almost_full=1 once count=14, full=1 and count=16 after the 16th push, overflow=1; popping 16 times returns 0x01..0x10 in order and empty=1 at the end.
REQ-021 Wrap-around: 40 words 0x00..0x27 pushed with pops interleaved, occupancy kept between 1 and 10 -> all 40 read back in order, no overflow or underflow.
REQ-022 Simultaneous events: push+pop at count=8 -> count stays 8; push+pop at count=0 -> count=1 and underflow=1; push+pop at count=16 -> count=15 and overflow=1.
REQ-023 FWFT=1: push 0x5A into an empty FIFO at cycle N -> rdata=0x5A and rvalid=1 at N+1 with no pop; one pop -> rvalid=0 and empty=1 on the next cycle.
REQ-024 Reset mid-operation: at count=9, assert rst together with push=1 and wdata=0x33 -> next cycle count=0, empty=1, all flags at their reset values, and 0x33 is never read back.
REQ-025 Error clear race: with overflow=1, assert clr_err in the same cycle as a pop on empty -> next cycle overflow=0, underflow=1.
